// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core, with a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to park the FSM in a TRAP state on unknown opcodes.
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        adr_src,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  imm_src,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXEC_R   = 4'd6;
  localparam logic [3:0] EXEC_I   = 4'd7;
  localparam logic [3:0] LUI      = 4'd8;
  localparam logic [3:0] AUIPC    = 4'd9;
  localparam logic [3:0] ALUWB    = 4'd10;
  localparam logic [3:0] JAL      = 4'd11;
  localparam logic [3:0] JALR     = 4'd12;
  localparam logic [3:0] JALR_PC  = 4'd13;
  localparam logic [3:0] BRANCH   = 4'd14;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] TRAP     = 4'd15;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       taken;

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXEC_R;
          OP_IMM:            state_next = EXEC_I;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          OP_LUI:            state_next = LUI;
          OP_AUIPC:          state_next = AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           state_next = TRAP;
`else
          default:           state_next = FETCH;
`endif
        endcase
      end
      MEMADR:   state_next = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (mem_ready) state_next = FETCH;
      EXEC_R, EXEC_I, LUI, AUIPC, JAL, JALR_PC: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      JALR:     state_next = JALR_PC;
      BRANCH:   state_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = FETCH;
    endcase
  end

  // A retirement is any entry into FETCH; TRAP never returns so it never retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      instret <= 32'd0;
    end else begin
      state <= state_next;
      if (state != FETCH && state_next == FETCH)
        instret <= instret + 32'd1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR, JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      ALUWB:    reg_write = 1'b1;
      JAL, JALR_PC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm_src = 3'b000;
      OP_STORE:                 imm_src = 3'b001;
      OP_BRANCH:                imm_src = 3'b101;
      OP_LUI, OP_AUIPC:         imm_src = 3'b010;
      OP_JAL:                   imm_src = 3'b110;
      default:                  imm_src = 3'b000;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model queues the expected
// per-cycle control word and instret; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero, lt, ltu, mem_ready;
  logic        pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]  imm_src;
  logic        illegal;
  logic [31:0] instret;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .adr_src(adr_src), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] cw;
    logic [31:0] ret;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic        plan_ready[$];
  logic [16:0] plan_cw[$];
  logic [31:0] model_ret;
  int          checks;
  int          failures;

  function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic rw,
                                     input logic mw, input logic adr, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [2:0] imm,
                                     input logic ill);
    return {pcw, irw, rw, mw, adr, res, a, b, op, imm, ill};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] opc);
    case (opc)
      7'h03, 7'h13, 7'h67: return 3'b000;
      7'h23:               return 3'b001;
      7'h63:               return 3'b101;
      7'h37, 7'h17:        return 3'b010;
      7'h6F:               return 3'b110;
      default:             return 3'b000;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic l, input logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addStep(input logic r, input logic [16:0] c);
    plan_ready.push_back(r);
    plan_cw.push_back(c);
  endtask

  // Builds one instruction's cycle-by-cycle plan from its class, queues the
  // expectations, then drives mem_ready per cycle. Entered at posedge+1 in FETCH.
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                               input logic l, input logic lu, input int fwait, input int mwait);
    logic [2:0]  im;
    logic [16:0] aluwb;
    logic        retire;
    plan_ready.delete();
    plan_cw.delete();
    opcode = opc; funct3 = f3; zero = z; lt = l; ltu = lu;
    im     = imm_of(opc);
    aluwb  = mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
    retire = 1'b1;
    for (int i = 0; i < fwait; i++)
      addStep(0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 0));
    addStep(1, mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 0));
    addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 0));
    case (opc)
      7'h03: begin
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0));
        for (int i = 0; i < mwait; i++)
          addStep(0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 0));
        addStep(1, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 0));
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, im, 0));
      end
      7'h23: begin
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0));
        for (int i = 0; i < mwait; i++)
          addStep(0, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 0));
        addStep(1, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 0));
      end
      7'h33: begin
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, im, 0));
        addStep(1'($urandom_range(0, 1)), aluwb);
      end
      7'h13: begin
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, im, 0));
        addStep(1'($urandom_range(0, 1)), aluwb);
      end
      7'h37: begin
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, im, 0));
        addStep(1'($urandom_range(0, 1)), aluwb);
      end
      7'h17: begin
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 0));
        addStep(1'($urandom_range(0, 1)), aluwb);
      end
      7'h6F: begin
        addStep(1'($urandom_range(0, 1)), mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0));
        addStep(1'($urandom_range(0, 1)), aluwb);
      end
      7'h67: begin
        addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0));
        addStep(1'($urandom_range(0, 1)), mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0));
        addStep(1'($urandom_range(0, 1)), aluwb);
      end
      7'h63: begin
        addStep(1'($urandom_range(0, 1)),
                mk(branch_taken(f3, z, l, lu), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, im, 0));
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++)
          addStep(1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1));
        retire = 1'b0;
`endif
      end
    endcase
    for (int i = 0; i < plan_cw.size(); i++)
      sbq.push_back('{cw: plan_cw[i], ret: model_ret});
    for (int i = 0; i < plan_ready.size(); i++) begin
      mem_ready = plan_ready[i];
      @(posedge clk);
      #1;
    end
    if (retire) model_ret = model_ret + 32'd1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checkOutput("ctrl", {15'd0, pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
                           alu_src_a, alu_src_b, alu_op, imm_src, illegal}, {15'd0, mon_e.cw});
      checkOutput("instret", instret, mon_e.ret);
    end
  end

  logic [6:0] ops[$];

  initial begin
    checks = 0; failures = 0; model_ret = 32'd0;
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'h00; funct3 = 3'd0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
`ifndef ILLEGAL_TRAP_EN
    ops.push_back(7'h7F);
    ops.push_back(7'h0B);
`endif
    #1;
    sbq.push_back('{cw: mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), ret: 32'd0});
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(7'h33, 3'b000, 0, 0, 0, 0, 0);
    applyStimulus(7'h03, 3'b010, 0, 0, 0, 0, 2);
    applyStimulus(7'h63, 3'b001, 1, 0, 0, 0, 0);
    applyStimulus(7'h63, 3'b001, 0, 0, 0, 0, 0);
    applyStimulus(7'h23, 3'b010, 0, 0, 0, 2, 1);
    applyStimulus(7'h67, 3'b000, 0, 0, 0, 1, 0);
    applyStimulus(7'h6F, 3'b000, 0, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++)
      applyStimulus(ops[$urandom_range(0, ops.size() - 1)], 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $urandom_range(0, 2));

    force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    model_ret = 32'hFFFF_FFFF;
    applyStimulus(7'h13, 3'b000, 0, 0, 0, 0, 0);
    applyStimulus(7'h37, 3'b000, 0, 0, 0, 0, 0);

    // Asynchronous reset while the store is holding in MEMWRITE.
    opcode = 7'h23; mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mem_write_before_reset", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mem_write_in_reset", {31'd0, mem_write}, 32'd0);
    checkOutput("adr_src_in_reset", {31'd0, adr_src}, 32'd0);
    checkOutput("pc_ir_write_in_reset", {30'd0, pc_write, ir_write}, 32'd0);
    checkOutput("instret_in_reset", instret, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    model_ret = 32'd0;
    @(posedge clk); #1;
    applyStimulus(7'h33, 3'b000, 0, 0, 0, 1, 0);

    applyStimulus(7'h7F, 3'b000, 0, 0, 0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
    applyStimulus(7'h17, 3'b000, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I core. It sequences the shared datapath: one memory port, one ALU, and the immediate extension unit, with the PC, IR and ALUOut registers. It also drives the enables and mux selects, including `ImmSrc`, for each instruction step by step. It tracks a retired-instruction count and supports wait states on the memory port.

## Interface
Parameters: none.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `zero`, `lt`, `ltu` in 1 each: ALU flags (equal, signed less-than, unsigned less-than).
- `mem_ready` in 1: memory access completes this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_write` out 1 each: register and memory write enables.
- `adr_src` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `result_src` out 2: result select, 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_src_a` out 2: ALU A select, 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `alu_src_b` out 2: ALU B select, 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `alu_op` out 2: ALU operation, 00 = add, 01 = sub/compare, 10 = decode from funct.
- `imm_src` out 3: immediate format, I = 000, S = 001, B = 101, U = 010, J = 110.
- `illegal` out 1: illegal-opcode trap active.
- `instret` out 32: retired-instruction counter.

## Operation
- State register and `instret` are the only flops. Outputs decode from the current state (Moore). The exceptions are `pc_write` in BRANCH and the `mem_ready` gating below.
- Outputs not listed for a state are 0.
- `imm_src` decodes from `opcode` in every state:
  - loads and OP-IMM/JALR: 000
  - stores: 001
  - branches: 101
  - LUI/AUIPC: 010
  - JAL: 110
  - anything else: 000
- States and transitions:
  - FETCH: `adr_src`=0, A=00, B=10, op=00, `result_src`=10. `ir_write` and `pc_write` = `mem_ready`. Holds while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
  - DECODE: A=01, B=01, op=00 (branch/JAL target into ALUOut). Next state by opcode:
    - 0000011 / 0100011 (load/store) → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - other → see Configuration
  - MEMADR: A=10, B=01, op=00. Load → MEMREAD; store → MEMWRITE.
  - MEMREAD: `adr_src`=1. Holds until `mem_ready`, then → MEMWB.
  - MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
  - MEMWRITE: `adr_src`=1, `mem_write`=1. Holds until `mem_ready`, then → FETCH.
  - EXEC_R: A=10, B=00, op=10 → ALUWB.
  - EXEC_I: A=10, B=01, op=10 → ALUWB.
  - LUI: A=11, B=01, op=00 → ALUWB.
  - AUIPC: A=01, B=01, op=00 → ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
  - JAL: A=01, B=10, op=00, `result_src`=00, `pc_write`=1 → ALUWB (rd = oldPC+4).
  - JALR: A=10, B=01, op=00 → JALR_PC.
  - JALR_PC: `result_src`=00, `pc_write`=1, A=01, B=10, op=00 → ALUWB.
  - BRANCH: A=10, B=00, op=01, `result_src`=00. `pc_write` = taken → FETCH. Taken by `funct3`:
    - 000: `zero`
    - 001: !`zero`
    - 100: `lt`
    - 101: !`lt`
    - 110: `ltu`
    - 111: !`ltu`
    - 010 / 011: never taken
- `instret` increments by 1 on every transition into FETCH from any other state. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async assert, any state): state = FETCH, `instret` = 0, `illegal` = 0.
  - `mem_write`, `reg_write` and `ir_write` drop immediately.
  - During and after reset, outputs are the FETCH values with `mem_ready` gating: `pc_write` = `ir_write` = 0 until `mem_ready`.
- Cycles per instruction with zero-wait memory:
  - branch: 3
  - R/I/LUI/AUIPC/store/JAL: 4
  - JALR/load: 5
  - Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored elsewhere.

## Configuration
- `ILLEGAL_TRAP_EN` defined: an unknown opcode in DECODE → TRAP.
  - TRAP drives `illegal`=1 and all enables 0.
  - TRAP is left only by reset; `instret` is not incremented.
- `ILLEGAL_TRAP_EN` undefined: an unknown opcode in DECODE → FETCH, treated as a NOP.
  - `instret` increments.
  - `illegal` is tied to 0; the port is still present.

## Test plan
- Reset, then ADD (0110011) with `mem_ready`=1 → FETCH→DECODE→EXEC_R→ALUWB→FETCH. `reg_write`=1 only in cycle 4; `instret`=1.
- LW with `mem_ready` low for 2 cycles in MEMREAD → total 7 cycles; `imm_src`=000; `result_src`=01 in MEMWB.
- BNE with `zero`=1 → `pc_write`=0 in BRANCH. BNE with `zero`=0 → `pc_write`=1, `imm_src`=101.
- `rst_n` pulsed low during MEMWRITE → `mem_write` falls within the same cycle; state is FETCH and `instret`=0 after release.
- Opcode 0x7F with `ILLEGAL_TRAP_EN` → `illegal`=1, held for 10 cycles, `instret` unchanged. Without the macro → back to FETCH and `instret`+1.
- Preload `instret` to 0xFFFFFFFF via 2^32-1 retirements, or force in simulation, then retire one instruction → `instret`=0.
